// File: rtl/result_accumulator_pkg.sv
// Shared constants for the operand-math stage and its result consumer.
// Both sides take the math latency from here so the valid strobe and the
// data path cannot drift apart.
package result_accumulator_pkg;

   // Pipeline depth of the math stage: input1 + input2*(input4-input3).
   localparam int MATH_LATENCY       = 3;

   // Default operand width of the math stage.
   localparam int DEFAULT_DATA_WIDTH = 8;

   // Width of the saturating dropped-block counter.
   localparam int DROP_WIDTH         = 8;

   // Width of a math-stage result for a given operand width.
   function automatic int result_width(input int data_width);
      return 2 * data_width;
   endfunction

   // Occupancy of the single-entry output register.
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

endpackage : result_accumulator_pkg

// File: rtl/result_accumulator_valid_delay_line.sv
// One-bit shift register that re-aligns a valid strobe with the output of a
// fixed-latency pipeline that carries no valid of its own. LATENCY must be at
// least 1; the output is the input delayed by exactly LATENCY clocks.
module valid_delay_line
   import result_accumulator_pkg::*;
#(
   parameter int LATENCY = MATH_LATENCY
) (
   input  logic clock,
   input  logic reset,
   input  logic in_valid,
   output logic out_valid
);

   logic [LATENCY-1:0] shift_d;
   logic [LATENCY-1:0] shift_q;

   // Shift the strobe one stage per clock, newest at bit 0.
   always_comb begin
      shift_d[0] = in_valid;
      for (int i = 1; i < LATENCY; i++) begin
         shift_d[i] = shift_q[i-1];
      end
   end

   // Delay line state; reset empties it so in-flight strobes are discarded.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
      end else begin
         // NOTE: non-blocking so every stage samples the previous value of its neighbour.
         shift_q <= shift_d;
      end
   end

   assign out_valid = shift_q[LATENCY-1];

endmodule : valid_delay_line

// File: rtl/result_accumulator.sv
// Consumer of the operand-math stage. Re-aligns operands_valid to the math
// latency, accumulates qualified results in blocks of 2^LOG2_COUNT samples
// (or shorter blocks on flush) and presents sum, average and sample count in
// a single-entry valid/ready register. Blocks that complete while that
// register is held are dropped and counted.
module result_accumulator
   import result_accumulator_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int LOG2_COUNT = 3,
   parameter  int LATENCY    = MATH_LATENCY,
   localparam int RES_WIDTH  = result_width(DATA_WIDTH),
   localparam int ACC_WIDTH  = RES_WIDTH + LOG2_COUNT,
   localparam int CNT_WIDTH  = LOG2_COUNT + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  operands_valid,
   input  logic [RES_WIDTH-1:0]  result,
   input  logic                  flush,
   output logic [ACC_WIDTH-1:0]  sum,
   output logic [RES_WIDTH-1:0]  average,
   output logic [CNT_WIDTH-1:0]  sample_count,
   output logic                  sum_valid,
   input  logic                  sum_ready,
   output logic [DROP_WIDTH-1:0] dropped_count
);

   localparam logic [CNT_WIDTH-1:0]  BLOCK_N  = CNT_WIDTH'(2 ** LOG2_COUNT);
   localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

   // Result strobe aligned with the math-stage output.
   logic                  result_valid;

   // Accumulation path.
   logic [ACC_WIDTH-1:0]  acc_d, acc_q;
   logic [CNT_WIDTH-1:0]  count_d, count_q;
   logic [ACC_WIDTH-1:0]  acc_sum;
   logic [CNT_WIDTH-1:0]  count_sum;
   logic                  block_done;
   logic                  flush_emit;
   logic                  emit;

   // Output register and drop counter.
   out_state_e            state_d, state_q;
   logic                  load;
   logic                  drop;
   logic [ACC_WIDTH-1:0]  sum_d, sum_q;
   logic [RES_WIDTH-1:0]  average_d, average_q;
   logic [CNT_WIDTH-1:0]  sample_count_d, sample_count_q;
   logic [DROP_WIDTH-1:0] dropped_d, dropped_q;

   valid_delay_line #(
      .LATENCY (LATENCY)
   ) u_valid_delay (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (operands_valid),
      .out_valid (result_valid)
   );

   // Add this cycle's sample and decide whether a block leaves this cycle.
   always_comb begin
      // NOTE: every combinational output gets a value on every path, so no latch is inferred.
      acc_sum    = acc_q;
      count_sum  = count_q;
      if (result_valid) begin
         acc_sum   = acc_q + ACC_WIDTH'(result);
         count_sum = count_q + CNT_WIDTH'(1);
      end
      // A full block and a coinciding flush produce a single emission.
      block_done = result_valid && (count_sum == BLOCK_N);
      flush_emit = flush && (count_sum != '0);
      emit       = block_done || flush_emit;
      // Clearing on emission lets the next cycle's sample open a new block.
      acc_d      = emit ? '0 : acc_sum;
      count_d    = emit ? '0 : count_sum;
   end

   // Accumulator and sample counter state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         count_q <= '0;
      end else begin
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

   // Output register occupancy, load/drop decode and held-value update.
   always_comb begin
      state_d        = state_q;
      load           = 1'b0;
      drop           = 1'b0;
      sum_d          = sum_q;
      average_d      = average_q;
      sample_count_d = sample_count_q;
      dropped_d      = dropped_q;

      unique case (state_q)
         OUT_EMPTY: begin
            if (emit) begin
               load    = 1'b1;
               state_d = OUT_FULL;
            end
         end
         OUT_FULL: begin
            if (sum_ready) begin
               // An emission in the accept cycle replaces the held entry.
               load    = emit;
               state_d = emit ? OUT_FULL : OUT_EMPTY;
            end else begin
               drop = emit;
            end
         end
         default: state_d = OUT_EMPTY;
      endcase

      if (load) begin
         sum_d          = acc_sum;
         average_d      = RES_WIDTH'(acc_sum >> LOG2_COUNT);
         sample_count_d = count_sum;
      end

      if (drop && (dropped_q != DROP_MAX)) begin
         dropped_d = dropped_q + DROP_WIDTH'(1);
      end
   end

   // Output register, held block values and drop counter state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= OUT_EMPTY;
         sum_q          <= '0;
         average_q      <= '0;
         sample_count_q <= '0;
         dropped_q      <= '0;
      end else begin
         state_q        <= state_d;
         sum_q          <= sum_d;
         average_q      <= average_d;
         sample_count_q <= sample_count_d;
         dropped_q      <= dropped_d;
      end
   end

   assign sum           = sum_q;
   assign average       = average_q;
   assign sample_count  = sample_count_q;
   assign sum_valid     = (state_q == OUT_FULL);
   assign dropped_count = dropped_q;

endmodule : result_accumulator

// File: tb/tb_result_accumulator.sv
// Self-checking bench for result_accumulator. A behavioural math stage feeds
// results with the fixed latency; a block-level reference model, driven from
// a per-cycle history of issued operand sets, predicts every output.
module tb_result_accumulator;
   import result_accumulator_pkg::*;

   localparam int DW    = 8;
   localparam int L2    = 3;
   localparam int LAT   = MATH_LATENCY;
   localparam int RW    = 2 * DW;
   localparam int AW    = RW + L2;
   localparam int N     = 2 ** L2;
   localparam int HIST  = 8192;

   logic          clock = 1'b0;
   logic          reset;
   logic          operands_valid;
   logic [RW-1:0] result;
   logic          flush;
   logic [AW-1:0] sum;
   logic [RW-1:0] average;
   logic [L2:0]   sample_count;
   logic          sum_valid;
   logic          sum_ready;
   logic [7:0]    dropped_count;

   result_accumulator #(
      .DATA_WIDTH (DW),
      .LOG2_COUNT (L2),
      .LATENCY    (LAT)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .operands_valid (operands_valid),
      .result         (result),
      .flush          (flush),
      .sum            (sum),
      .average        (average),
      .sample_count   (sample_count),
      .sum_valid      (sum_valid),
      .sum_ready      (sum_ready),
      .dropped_count  (dropped_count)
   );

   always #5 clock = ~clock;

   // Behavioural math stage: value presented with the operands appears LAT clocks later.
   logic [RW-1:0] math_in;
   logic [RW-1:0] math_pipe [LAT];

   always @(posedge clock) begin
      math_pipe[0] <= math_in;
      for (int i = 1; i < LAT; i++) math_pipe[i] <= math_pipe[i-1];
   end

   assign result = math_pipe[LAT-1];

   // Bookkeeping.
   int n_checks = 0;
   int n_errors = 0;

   // Issue history and reference model state.
   int          cyc;
   int          last_rst;
   bit          issue_v [HIST];
   logic [15:0] issue_r [HIST];
   longint      m_acc;
   int          m_cnt;
   bit          m_full;
   longint      m_sum;
   longint      m_avg;
   int          m_scnt;
   int          m_drop;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   function automatic logic [15:0] math_f(input int a, input int b, input int c, input int d);
      int r;
      r = a + b * (d - c);
      return 16'(r);
   endfunction

   task automatic model_clear();
      m_acc  = 0;
      m_cnt  = 0;
      m_full = 0;
      m_sum  = 0;
      m_avg  = 0;
      m_scnt = 0;
      m_drop = 0;
   endtask

   // One clock of the reference model, from the block-level rules.
   task automatic model_cycle(input bit fl, input bit rd);
      bit     s;
      longint r;
      longint na;
      int     nc;
      bit     emit;
      s = 0;
      r = 0;
      if (cyc >= LAT && (cyc - LAT) > last_rst && issue_v[cyc-LAT]) begin
         s = 1;
         r = longint'(issue_r[cyc-LAT]);
      end
      na   = m_acc + r;
      nc   = m_cnt + int'(s);
      emit = (s && nc == N) || (fl && nc > 0);
      if (emit) begin
         if (!m_full || rd) begin
            m_full = 1;
            m_sum  = na;
            m_avg  = na / N;
            m_scnt = nc;
         end else if (m_drop < 255) begin
            m_drop++;
         end
         m_acc = 0;
         m_cnt = 0;
      end else begin
         m_acc = na;
         m_cnt = nc;
         if (m_full && rd) m_full = 0;
      end
   endtask

   task automatic check_outputs();
      check("sum_valid", 64'(sum_valid), 64'(m_full));
      check("sum", 64'(sum), 64'(m_sum));
      check("average", 64'(average), 64'(m_avg));
      check("sample_count", 64'(sample_count), 64'(m_scnt));
      check("dropped_count", 64'(dropped_count), 64'(m_drop));
   endtask

   // Drive one cycle of inputs at the falling edge, clock it, check at the next falling edge.
   task automatic step(input bit ov, input logic [15:0] r, input bit fl, input bit rd);
      operands_valid = ov;
      math_in        = r;
      flush          = fl;
      sum_ready      = rd;
      issue_v[cyc]   = ov;
      issue_r[cyc]   = r;
      model_cycle(fl, rd);
      @(posedge clock);
      @(negedge clock);
      cyc++;
      check_outputs();
   endtask

   task automatic issue(input logic [15:0] r, input bit rd);
      step(1'b1, r, 1'b0, rd);
   endtask

   task automatic idle(input int n, input bit rd);
      repeat (n) step(1'b0, 16'h0, 1'b0, rd);
   endtask

   task automatic do_reset();
      operands_valid = 1'b0;
      flush          = 1'b0;
      sum_ready      = 1'b0;
      math_in        = '0;
      issue_v[cyc]   = 1'b0;
      last_rst       = cyc;
      reset          = 1'b1;
      model_clear();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      cyc++;
      check_outputs();
   endtask

   initial begin
      longint sa;
      longint sc;
      logic [15:0] v;

      for (int i = 0; i < LAT; i++) math_pipe[i] = '0;
      cyc      = 0;
      last_rst = -1;
      model_clear();
      do_reset();
      check("reset_sum", 64'(sum), 64'd0);
      check("reset_valid", 64'(sum_valid), 64'd0);

      // Eight samples of 0 + 1*(3-2) = 1; output appears LAT+1 cycles after the 8th valid.
      for (int i = 0; i < N; i++) issue(math_f(0, 1, 2, 3), 1'b1);
      idle(2, 1'b1);
      check("t1_not_early", 64'(sum_valid), 64'd0);
      idle(1, 1'b1);
      check("t1_valid", 64'(sum_valid), 64'd1);
      check("t1_sum", 64'(sum), 64'd8);
      check("t1_avg", 64'(average), 64'd1);
      check("t1_cnt", 64'(sample_count), 64'd8);
      idle(1, 1'b1);
      check("t1_one_cycle", 64'(sum_valid), 64'd0);

      // Maximum results must not wrap the accumulator.
      for (int i = 0; i < N; i++) issue(16'hFFFF, 1'b1);
      idle(3, 1'b1);
      check("t2_sum", 64'(sum), 64'h7FFF8);
      check("t2_avg", 64'(average), 64'hFFFF);
      check("t2_cnt", 64'(sample_count), 64'd8);
      idle(1, 1'b1);

      // Partial block flushed; then a flush with nothing accumulated.
      for (int i = 0; i < 3; i++) issue(16'd5, 1'b1);
      idle(3, 1'b1);
      check("t3_no_early", 64'(sum_valid), 64'd0);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      check("t3_valid", 64'(sum_valid), 64'd1);
      check("t3_sum", 64'(sum), 64'd15);
      check("t3_cnt", 64'(sample_count), 64'd3);
      check("t3_avg", 64'(average), 64'd1);
      idle(1, 1'b1);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      check("t3_empty_flush", 64'(sum_valid), 64'd0);
      check("t3_retained", 64'(sum), 64'd15);

      // Back-pressure: block A held, block B dropped, block C loads as A is accepted.
      sa = 0;
      for (int i = 0; i < N; i++) begin
         v = 16'($urandom);
         sa += longint'(v);
         issue(v, 1'b0);
      end
      idle(3, 1'b0);
      check("t4_a_valid", 64'(sum_valid), 64'd1);
      check("t4_a_sum", 64'(sum), 64'(sa));
      for (int i = 0; i < N; i++) issue(16'($urandom), 1'b0);
      idle(3, 1'b0);
      check("t4_drop", 64'(dropped_count), 64'd1);
      check("t4_a_held", 64'(sum), 64'(sa));
      sc = 0;
      for (int i = 0; i < N; i++) begin
         v = 16'($urandom);
         sc += longint'(v);
         issue(v, 1'b0);
      end
      idle(2, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      check("t4_c_valid", 64'(sum_valid), 64'd1);
      check("t4_c_sum", 64'(sum), 64'(sc));
      check("t4_no_drop", 64'(dropped_count), 64'd1);
      idle(1, 1'b1);
      check("t4_drained", 64'(sum_valid), 64'd0);

      // Flush coinciding with the 8th sample: one emission only.
      for (int i = 0; i < N; i++) issue(16'd7, 1'b1);
      idle(2, 1'b1);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      check("t5_valid", 64'(sum_valid), 64'd1);
      check("t5_cnt", 64'(sample_count), 64'd8);
      check("t5_sum", 64'(sum), 64'd56);
      idle(1, 1'b1);
      check("t5_single", 64'(sum_valid), 64'd0);
      issue(16'd9, 1'b1);
      idle(3, 1'b1);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      check("t5_new_cnt", 64'(sample_count), 64'd1);
      check("t5_new_sum", 64'(sum), 64'd9);
      idle(1, 1'b1);

      // Reset after 5 samples with 2 operand sets still in flight.
      for (int i = 0; i < 5; i++) issue(16'd3, 1'b1);
      idle(1, 1'b1);
      issue(16'd100, 1'b1);
      issue(16'd100, 1'b1);
      do_reset();
      check("t6_sum", 64'(sum), 64'd0);
      check("t6_avg", 64'(average), 64'd0);
      check("t6_cnt", 64'(sample_count), 64'd0);
      check("t6_valid", 64'(sum_valid), 64'd0);
      check("t6_drop", 64'(dropped_count), 64'd0);
      idle(5, 1'b1);
      check("t6_inflight_ignored", 64'(sum_valid), 64'd0);
      for (int i = 0; i < N; i++) issue(16'd2, 1'b1);
      idle(3, 1'b1);
      check("t6_block_sum", 64'(sum), 64'd16);
      check("t6_block_cnt", 64'(sample_count), 64'd8);
      idle(1, 1'b1);

      // Randomised traffic: operands, flushes and back-pressure.
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 9) < 7),
              math_f(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255))),
              1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 9) < ((i < 750) ? 8 : 3)));
      end

      // Continuous samples with the output never accepted: drop counter saturates.
      for (int i = 0; i < 2200; i++) issue(16'($urandom), 1'b0);
      check("sat_drop", 64'(dropped_count), 64'd255);
      idle(4, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_result_accumulator
